poly_eval_engine: RTL and testbench

Horner-method fixed-point polynomial evaluator; successor to the single-function Taylor MAC.
- Holds NUM_FUNCS runtime-writable coefficient banks (tanh, exp, sigmoid, ...).
- Buffers samples in an input FIFO; each sample carries its own function select and term count.
- Returns results over a valid/ready output port with backpressure.
- Sits between the activation-input stream and the downstream writeback stage of the NLA datapath.

---
 rtl/poly_eval_pkg.sv | 67 ++++++
 rtl/poly_eval_fifo.sv | 54 +++++
 rtl/poly_eval_engine.sv | 207 ++++++++++++++++++++
 tb/tb_poly_eval_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_eval_pkg.sv
// Shared types and arithmetic helpers for the Horner polynomial engine.
// Helpers take values widened to WIDE bits, so DATA_WIDTH is limited to 32.
// Feature macro POLY_SAT_EN: clamp overflowing results; otherwise they wrap.
package poly_eval_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_ADD,
    S_OUT
  } state_t;

  // Working width for intermediate products and sums.
  localparam int WIDE = 64;

  // Clamp rails for the default 32-bit datapath.
  localparam logic [31:0] ST_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] ST_MIN = 32'h8000_0000;

  typedef struct packed {
    logic            ovf;
    logic [WIDE-1:0] val;
  } fit_t;

  function automatic int func_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int term_w(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int addr_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Range-check a wide signed value against a w-bit signed result.
  // The low w bits of .val are the result (wrapped or clamped).
  function automatic fit_t fit_width(input logic signed [WIDE-1:0] v, input int w);
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    fit_t                   r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = ~hi;
    r.ovf = (v > hi) || (v < lo);
`ifdef POLY_SAT_EN
    if (v > hi)      r.val = hi;
    else if (v < lo) r.val = lo;
    else             r.val = v;
`else
    r.val = v;
`endif
    return r;
  endfunction

  // Full-precision product, arithmetic shift back to the fixed-point scale.
  function automatic fit_t sat_mul(input logic signed [WIDE-1:0] prod, input int frac, input int w);
    return fit_width(prod >>> frac, w);
  endfunction

  function automatic fit_t sat_add(input logic signed [WIDE-1:0] a,
                                   input logic signed [WIDE-1:0] b, input int w);
    return fit_width(a + b, w);
  endfunction

endpackage

// File: rtl/poly_eval_fifo.sv
// Synchronous FIFO holding queued samples, with occupancy count.
// Latency: written entry visible at the head the cycle after push.
// Backpressure: full_o blocks pushes; simultaneous push and pop both honoured.
module poly_eval_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (r_count == CNT_W'(DEPTH));
  assign empty_o   = (r_count == '0);
  assign count_o   = r_count;
  assign rdat_o    = r_mem[r_rd_ptr];
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  // Storage array: no reset needed, entries are only read once counted.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdat_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/poly_eval_engine.sv
// Horner fixed-point polynomial evaluator with NUM_FUNCS writable coefficient banks.
// Latency: pop to out_valid_o is 2T cycles; one result every 2T+1 cycles.
// Backpressure: in_ready_o = FIFO not full; result held in OUT until out_ready_i.
// Feature macro POLY_SAT_EN (in poly_eval_pkg): clamp instead of wrap on overflow.
module poly_eval_engine
  import poly_eval_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MAX_TERMS  = 16,
  parameter int NUM_FUNCS  = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int FUNC_W = func_w(NUM_FUNCS),
  localparam int TERM_W = term_w(MAX_TERMS),
  localparam int ADDR_W = addr_w(MAX_TERMS),
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [FUNC_W-1:0]     in_func_i,
  input  logic [TERM_W-1:0]     in_terms_i,
  input  logic                  cfg_we_i,
  output logic                  cfg_ready_o,
  input  logic [FUNC_W-1:0]     cfg_func_i,
  input  logic [ADDR_W-1:0]     cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [FUNC_W-1:0]     out_func_o,
  output logic                  busy_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  ovf_o,
  input  logic                  ovf_clr_i
);

  localparam int ENT_W = DATA_WIDTH + FUNC_W + TERM_W;

  // Sample queue
  logic [ENT_W-1:0]      w_fifo_wdat;
  logic [ENT_W-1:0]      w_fifo_rdat;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_head_x;
  logic [FUNC_W-1:0]     w_head_func;
  logic [TERM_W-1:0]     w_head_terms;
  logic [TERM_W-1:0]     w_terms_eff;

  // Evaluation state
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_prod;
  logic [FUNC_W-1:0]     r_func;
  logic [TERM_W-1:0]     r_terms;
  logic [ADDR_W-1:0]     r_idx;
  logic                  r_out_vld;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_coef [NUM_FUNCS][MAX_TERMS];

  // Arithmetic
  logic [ADDR_W-1:0]      w_load_addr;
  logic [DATA_WIDTH-1:0]  w_load_coef;
  logic [DATA_WIDTH-1:0]  w_add_coef;
  logic signed [WIDE-1:0] w_prod_full;
  fit_t                   w_mul_fit;
  fit_t                   w_add_fit;
  logic [DATA_WIDTH-1:0]  w_mul_res;
  logic [DATA_WIDTH-1:0]  w_add_res;
  logic                   w_ovf_set;
  logic                   w_unused_hi;

  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_fifo_wdat = {in_data_i, in_func_i, in_terms_i};

  assign w_head_x     = w_fifo_rdat[ENT_W-1 -: DATA_WIDTH];
  assign w_head_func  = w_fifo_rdat[TERM_W +: FUNC_W];
  assign w_head_terms = w_fifo_rdat[TERM_W-1:0];

  poly_eval_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .wdat_i  (w_fifo_wdat),
    .pop_i   (w_pop),
    .rdat_o  (w_fifo_rdat),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_level_o)
  );

  // Term count of 0 means a constant (1 term); anything past MAX_TERMS is clamped.
  always_comb begin
    w_terms_eff = w_head_terms;
    if (w_head_terms == '0)                        w_terms_eff = TERM_W'(1);
    else if (w_head_terms > TERM_W'(MAX_TERMS))    w_terms_eff = TERM_W'(MAX_TERMS);
  end

  assign w_load_addr = ADDR_W'(r_terms - TERM_W'(1));
  assign w_load_coef = r_coef[r_func][w_load_addr];
  assign w_add_coef  = r_coef[r_func][r_idx];

  assign w_prod_full = WIDE'(signed'(r_acc)) * WIDE'(signed'(r_x));
  assign w_mul_fit   = sat_mul(w_prod_full, FRAC_BITS, DATA_WIDTH);
  assign w_add_fit   = sat_add(WIDE'(signed'(r_prod)), WIDE'(signed'(w_add_coef)), DATA_WIDTH);
  assign w_mul_res   = w_mul_fit.val[DATA_WIDTH-1:0];
  assign w_add_res   = w_add_fit.val[DATA_WIDTH-1:0];
  assign w_unused_hi = ^{w_mul_fit.val[WIDE-1:DATA_WIDTH], w_add_fit.val[WIDE-1:DATA_WIDTH]};

  assign w_ovf_set = ((r_state == S_MUL) && w_mul_fit.ovf) ||
                     ((r_state == S_ADD) && w_add_fit.ovf);

  assign in_ready_o  = !w_full && !rst_i;
  assign cfg_ready_o = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE) || !w_empty;
  assign out_valid_o = r_out_vld;
  assign out_data_o  = r_acc;
  assign out_func_o  = r_func;
  assign ovf_o       = r_ovf;

  // Coefficient banks: writes only land while the engine is idle, so an
  // evaluation always sees one consistent set of coefficients.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int f = 0; f < NUM_FUNCS; f++) begin
        for (int k = 0; k < MAX_TERMS; k++) begin
          r_coef[f][k] <= '0;
        end
      end
    end else if (cfg_we_i && (r_state == S_IDLE)) begin
      r_coef[cfg_func_i][cfg_addr_i] <= cfg_data_i;
    end
  end

  // Horner sequencer: acc = c[T-1], then acc = ((acc*x)>>>F) + c[idx] down to idx 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
      r_func    <= '0;
      r_terms   <= '0;
      r_idx     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_x     <= w_head_x;
            r_func  <= w_head_func;
            r_terms <= w_terms_eff;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc <= w_load_coef;
          r_idx <= ADDR_W'(r_terms - TERM_W'(2));
          if (r_terms == TERM_W'(1)) begin
            r_out_vld <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod  <= w_mul_res;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_acc <= w_add_res;
          if (r_idx == '0) begin
            r_out_vld <= 1'b1;
            r_state   <= S_OUT;
          end else begin
            r_idx   <= r_idx - ADDR_W'(1);
            r_state <= S_MUL;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            r_out_vld <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (ovf_clr_i) r_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_poly_eval_engine.sv
// Self-checking bench for poly_eval_engine: directed scenarios plus randomized
// samples checked against a plain-arithmetic fixed-point reference model.
module tb_poly_eval_engine;
  import poly_eval_pkg::*;

  localparam longint LMAX = longint'(signed'(ST_MAX));
  localparam longint LMIN = longint'(signed'(ST_MIN));

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_func;
  logic [4:0]  in_terms;
  logic        cfg_we;
  logic        cfg_ready;
  logic [1:0]  cfg_func;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_func;
  logic        busy;
  logic [3:0]  level;
  logic        ovf;
  logic        ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_coef [4][16];

  always #5 clk = ~clk;

  poly_eval_engine dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_data_i    (in_data),
    .in_func_i    (in_func),
    .in_terms_i   (in_terms),
    .cfg_we_i     (cfg_we),
    .cfg_ready_o  (cfg_ready),
    .cfg_func_i   (cfg_func),
    .cfg_addr_i   (cfg_addr),
    .cfg_data_i   (cfg_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_func_o   (out_func),
    .busy_o       (busy),
    .fifo_level_o (level),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit oor(input longint v);
    return (v > LMAX) || (v < LMIN);
  endfunction

  function automatic longint clip(input longint v);
`ifdef POLY_SAT_EN
    if (v > LMAX) return LMAX;
    if (v < LMIN) return LMIN;
    return v;
`else
    return longint'(signed'(v[31:0]));
`endif
  endfunction

  function automatic int eff_terms(input int t);
    return (t == 0) ? 1 : ((t > 16) ? 16 : t);
  endfunction

  // Reference: value of sum c_k x^k evaluated Horner-style in Q16.16,
  // each product floored by the 16-bit shift, every step range-checked.
  task automatic model(input logic [31:0] x, input int f, input int t,
                       output logic [31:0] res, output bit ov);
    int     n;
    longint acc;
    longint xs;
    longint p;
    n   = eff_terms(t);
    xs  = longint'(signed'(x));
    acc = longint'(signed'(m_coef[f][n-1]));
    ov  = 1'b0;
    for (int i = n - 2; i >= 0; i--) begin
      p = (acc * xs) >>> 16;
      if (oor(p)) ov = 1'b1;
      p   = clip(p);
      acc = p + longint'(signed'(m_coef[f][i]));
      if (oor(acc)) ov = 1'b1;
      acc = clip(acc);
    end
    res = acc[31:0];
  endtask

  task automatic cfg_write(input int f, input int k, input logic [31:0] d);
    bit done;
    done     = 1'b0;
    cfg_we   = 1'b1;
    cfg_func = 2'(f);
    cfg_addr = 4'(k);
    cfg_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cfg_ready) done = 1'b1;
      tick();
    end
    cfg_we = 1'b0;
    chk("cfg_accept", 64'(done), 64'd1);
    if (done) m_coef[f][k] = d;
  endtask

  // Push one sample into an idle engine and wait (bounded) for its result.
  task automatic run_sample(input logic [31:0] x, input int f, input int t,
                            input bit clr_push, input bit clr_hold,
                            output int lat, output logic [31:0] d,
                            output logic [1:0] fo, output bit ov, output bit ok);
    chk("push_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = x;
    in_func  = 2'(f);
    in_terms = 5'(t);
    ovf_clr  = clr_push;
    tick();
    in_valid = 1'b0;
    ovf_clr  = clr_hold;
    lat = 1;
    ok  = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    d  = out_data;
    fo = out_func;
    ov = ovf;
    tick();
  endtask

  function automatic logic [31:0] rnd_coef();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, 32'h7FFFF)) - 32'h40000;
  endfunction

  function automatic logic [31:0] rnd_x();
    if ($urandom_range(0, 9) == 0) return $urandom();
    return 32'($urandom_range(0, 32'h30000)) - 32'h18000;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic [31:0] d0;
    logic [31:0] exp_d;
    logic [1:0]  fo;
    bit          ov;
    bit          exp_ov;
    bit          ok;
    int          f;
    int          t;
    logic [31:0] x;
    int          got;
    logic [31:0] q_dat [$];
    logic [1:0]  q_fn  [$];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_func = '0; in_terms = '0;
    cfg_we = 1'b0; cfg_func = '0; cfg_addr = '0; cfg_data = '0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    for (int a = 0; a < 4; a++) for (int k = 0; k < 16; k++) m_coef[a][k] = '0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_func",  64'(out_func),  64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_level",     64'(level),     64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // 1 + 2x + 3x^2 at x=2.0 -> 17.0
    cfg_write(0, 0, 32'h0001_0000);
    cfg_write(0, 1, 32'h0002_0000);
    cfg_write(0, 2, 32'h0003_0000);
    run_sample(32'h0002_0000, 0, 3, 1'b1, 1'b0, lat, d, fo, ov, ok);
    model(32'h0002_0000, 0, 3, exp_d, exp_ov);
    chk("t3_done",  64'(ok),  64'd1);
    chk("t3_lat",   64'(lat), 64'd7);
    chk("t3_data",  64'(d),   64'h0011_0000);
    chk("t3_model", 64'(d),   64'(exp_d));
    chk("t3_func",  64'(fo),  64'd0);

    // Constant polynomial with T=1 and T=0
    cfg_write(2, 0, 32'hFFFF_0000);
    run_sample($urandom(), 2, 1, 1'b1, 1'b0, lat, d, fo, ov, ok);
    chk("t1_lat",  64'(lat), 64'd3);
    chk("t1_data", 64'(d),   64'hFFFF_0000);
    chk("t1_func", 64'(fo),  64'd2);
    run_sample($urandom(), 2, 0, 1'b1, 1'b0, lat, d, fo, ov, ok);
    chk("t0_lat",  64'(lat), 64'd3);
    chk("t0_data", 64'(d),   64'hFFFF_0000);
    chk("t0_func", 64'(fo),  64'd2);

    // Overflow with clear held: set must win over clear, then clear takes effect
    cfg_write(1, 0, 32'h7FFF_0000);
    cfg_write(1, 1, 32'h7FFF_0000);
    run_sample(32'h0001_0000, 1, 2, 1'b1, 1'b1, lat, d, fo, ov, ok);
    model(32'h0001_0000, 1, 2, exp_d, exp_ov);
`ifdef POLY_SAT_EN
    chk("ovf_data", 64'(d), 64'h7FFF_FFFF);
`else
    chk("ovf_data", 64'(d), 64'hFFFE_0000);
`endif
    chk("ovf_model",   64'(d),   64'(exp_d));
    chk("ovf_set_win", 64'(ov),  64'd1);
    chk("ovf_cleared", 64'(ovf), 64'd0);
    ovf_clr = 1'b0;
    // Sticky across a later clean evaluation
    run_sample(32'h0001_0000, 1, 2, 1'b1, 1'b0, lat, d, fo, ov, ok);
    run_sample(32'h0002_0000, 0, 3, 1'b0, 1'b0, lat, d, fo, ov, ok);
    chk("ovf_sticky", 64'(ov), 64'd1);
    chk("ovf_sticky_data", 64'(d), 64'h0011_0000);

    // cfg write held from MUL: dropped until IDLE, then used by next sample
    cfg_write(3, 0, 32'h0001_0000);
    cfg_write(3, 1, 32'h0001_0000);
    cfg_write(3, 2, 32'h0000_0000);
    model(32'h0002_0000, 3, 3, exp_d, exp_ov);
    in_valid = 1'b1; in_data = 32'h0002_0000; in_func = 2'd3; in_terms = 5'd3;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    cfg_we = 1'b1; cfg_func = 2'd3; cfg_addr = 4'd0; cfg_data = 32'h0005_0000;
    chk("cfg_mul_ready", 64'(cfg_ready), 64'd0);
    ok = 1'b0; d = '0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) d = out_data;
      if (cfg_ready) ok = 1'b1;
      tick();
    end
    cfg_we = 1'b0;
    chk("cfg_mul_accept", 64'(ok), 64'd1);
    chk("cfg_mul_old",    64'(d),  64'(exp_d));
    chk("cfg_mul_old_k",  64'(d),  64'h0003_0000);
    m_coef[3][0] = 32'h0005_0000;
    run_sample(32'h0002_0000, 3, 3, 1'b1, 1'b0, lat, d, fo, ov, ok);
    model(32'h0002_0000, 3, 3, exp_d, exp_ov);
    chk("cfg_mul_new",   64'(d), 64'(exp_d));
    chk("cfg_mul_new_k", 64'(d), 64'h0007_0000);

    // Random coefficients and samples against the reference model
    for (int a = 0; a < 4; a++)
      for (int k = 0; k < 16; k++) cfg_write(a, k, rnd_coef());
    for (int n = 0; n < 40; n++) begin
      f = $urandom_range(0, 3);
      t = $urandom_range(0, 20);
      x = rnd_x();
      model(x, f, t, exp_d, exp_ov);
      run_sample(x, f, t, 1'b1, 1'b0, lat, d, fo, ov, ok);
      chk("rnd_lat",  64'(lat), 64'(1 + 2 * eff_terms(t)));
      chk("rnd_data", 64'(d),   64'(exp_d));
      chk("rnd_func", 64'(fo),  64'(f));
      chk("rnd_ovf",  64'(ov),  64'(exp_ov));
    end

    // Backpressure: 9 back-to-back pushes with the output stalled
    out_ready = 1'b0;
    for (int n = 0; n < 9; n++) begin
      f = $urandom_range(0, 3);
      t = $urandom_range(0, 4);
      x = rnd_x();
      model(x, f, t, exp_d, exp_ov);
      q_dat.push_back(exp_d);
      q_fn.push_back(2'(f));
      chk("bp_push_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1; in_data = x; in_func = 2'(f); in_terms = 5'(t);
      tick();
    end
    in_valid = 1'b0;
    chk("bp_level_full", 64'(level),    64'd8);
    chk("bp_ready_low",  64'(in_ready), 64'd0);
    chk("bp_busy",       64'(busy),     64'd1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
    chk("bp_first_valid", 64'(ok), 64'd1);
    d0 = out_data;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_data",  64'(out_data),  64'(d0));
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 1000 && got < 9; i++) begin
      if (out_valid) begin
        chk("bp_data", 64'(out_data), 64'(q_dat.pop_front()));
        chk("bp_func", 64'(out_func), 64'(q_fn.pop_front()));
        got++;
      end
      tick();
    end
    chk("bp_count",       64'(got),   64'd9);
    chk("bp_level_empty", 64'(level), 64'd0);

    // Reset in the middle of ADD with three samples queued
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_data = 32'h0001_8000; in_func = 2'd0; in_terms = 5'd3;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_level", 64'(level), 64'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level),     64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < 4; a++) for (int k = 0; k < 16; k++) m_coef[a][k] = '0;
    tick();
    chk("post_mid_valid", 64'(out_valid), 64'd0);
    run_sample(32'h0002_0000, 0, 3, 1'b1, 1'b0, lat, d, fo, ov, ok);
    model(32'h0002_0000, 0, 3, exp_d, exp_ov);
    chk("rst_coef0",   64'(d),   64'd0);
    chk("rst_coef0_m", 64'(d),   64'(exp_d));
    chk("rst_lat",     64'(lat), 64'd7);
    run_sample(32'h0002_0000, 2, 1, 1'b1, 1'b0, lat, d, fo, ov, ok);
    chk("rst_coef2",   64'(d),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
